// File: rtl/rv_alu_pkg.sv
// -----------------------------------------------------------------------------
// rv_alu_pkg
// Shared RV32I constants for the ALU decoder and the ALU itself: major opcodes,
// funct3/funct7 field values, the 5-bit ALU operation codes and the decoded
// bundle that travels from the decoder to the ALU stage.
// -----------------------------------------------------------------------------
package rv_alu_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;  // register-register
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;  // register-immediate

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;  // selects SUB / SRA / SRAI

   localparam int ALU_OP_N = 19;

   typedef enum logic [4:0] {
      ALU_ADD   = 5'd0,  ALU_ADDI  = 5'd1,  ALU_SUB   = 5'd2,  ALU_XOR   = 5'd3,
      ALU_XORI  = 5'd4,  ALU_OR    = 5'd5,  ALU_ORI   = 5'd6,  ALU_AND   = 5'd7,
      ALU_ANDI  = 5'd8,  ALU_SLL   = 5'd9,  ALU_SLLI  = 5'd10, ALU_SRL   = 5'd11,
      ALU_SRLI  = 5'd12, ALU_SRA   = 5'd13, ALU_SRAI  = 5'd14, ALU_SLT   = 5'd15,
      ALU_SLTI  = 5'd16, ALU_SLTU  = 5'd17, ALU_SLTIU = 5'd18
   } alu_op_e;

   typedef struct packed {
      alu_op_e               alu_op;
      logic [ALU_OP_N-1:0]   alu_en;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [4:0]            rd;
      logic [31:0]           imm;
      logic                  use_imm;
      logic                  illegal;
   } dec_t;

   function automatic logic [ALU_OP_N-1:0] alu_onehot(input alu_op_e op);
      return {{(ALU_OP_N-1){1'b0}}, 1'b1} << op;
   endfunction

endpackage

// File: rtl/rv_alu_dec_comb.sv
// -----------------------------------------------------------------------------
// rv_alu_dec_comb
// Purely combinational RV32I ALU-instruction decoder.
//   instr  in   32  instruction word
//   dec    out  dec_t  decoded bundle (op, one-hot enable, register fields,
//                      immediate, immediate select, illegal flag)
// Unsupported words produce illegal=1 with op/enable/immediate/use_imm all 0;
// the register fields are always the raw instruction slices.
// -----------------------------------------------------------------------------
module rv_alu_dec_comb
   import rv_alu_pkg::*;
(
   input  logic [31:0] instr,
   output dec_t        dec
);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   alu_op_e     op;
   logic        legal;
   logic        is_imm;
   logic [31:0] imm;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];

   always_comb begin
      // NOTE: every variable gets a default first so no path through the case leaves a latch.
      op     = ALU_ADD;
      legal  = 1'b1;
      is_imm = 1'b0;
      imm    = '0;
      case (opcode)
         OPC_OP: begin
            if (f7 == F7_BASE) begin
               case (f3)
                  F3_ADD_SUB: op = ALU_ADD;
                  F3_SLL:     op = ALU_SLL;
                  F3_SLT:     op = ALU_SLT;
                  F3_SLTU:    op = ALU_SLTU;
                  F3_XOR:     op = ALU_XOR;
                  F3_SRL_SRA: op = ALU_SRL;
                  F3_OR:      op = ALU_OR;
                  F3_AND:     op = ALU_AND;
               endcase
            end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
               op = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == F3_SRL_SRA) begin
               op = ALU_SRA;
            end else begin
               legal = 1'b0;
            end
         end
         OPC_OP_IMM: begin
            is_imm = 1'b1;
            imm    = {{20{instr[31]}}, instr[31:20]};
            case (f3)
               F3_ADD_SUB: op = ALU_ADDI;
               F3_SLT:     op = ALU_SLTI;
               F3_SLTU:    op = ALU_SLTIU;
               F3_XOR:     op = ALU_XORI;
               F3_OR:      op = ALU_ORI;
               F3_AND:     op = ALU_ANDI;
               F3_SLL: begin
                  // Shifts carry a 5-bit shamt; the upper bits are a funct7 qualifier.
                  op    = ALU_SLLI;
                  imm   = {27'b0, instr[24:20]};
                  legal = (f7 == F7_BASE);
               end
               F3_SRL_SRA: begin
                  imm = {27'b0, instr[24:20]};
                  if (f7 == F7_BASE)     op = ALU_SRLI;
                  else if (f7 == F7_ALT) op = ALU_SRAI;
                  else                   legal = 1'b0;
               end
            endcase
         end
         default: legal = 1'b0;
      endcase

      dec.alu_op  = legal ? op : ALU_ADD;
      dec.alu_en  = legal ? alu_onehot(op) : '0;
      dec.rs1     = instr[19:15];
      dec.rs2     = instr[24:20];
      dec.rd      = instr[11:7];
      dec.imm     = legal ? imm : '0;
      dec.use_imm = legal && is_imm;
      dec.illegal = !legal;
   end

endmodule

// File: rtl/rv_alu_decoder.sv
// -----------------------------------------------------------------------------
// rv_alu_decoder
// Registered RV32I ALU decoder stage with valid/ready handshakes on both sides.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous kill: empties the stage, drops the input word
//   in_valid   in   / in_ready out / in_instr in[32]   upstream handshake
//   out_valid  out  / out_ready in                     downstream handshake
//   out_alu_op[5], out_alu_en[19], out_rs1/rs2/rd[5], out_imm[32],
//   out_use_imm, out_illegal                           decoded bundle
// Build option DECODER_SKID_EN: two-entry skid buffer with a registered
// in_ready (skid slot empty), breaking the out_ready -> in_ready path.
// Without it a single output register is used and
// in_ready = !out_valid || out_ready. Latency is one cycle in both builds.
// -----------------------------------------------------------------------------
module rv_alu_decoder
   import rv_alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_alu_op,
   output logic [18:0] out_alu_en,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic [31:0] out_imm,
   output logic        out_use_imm,
   output logic        out_illegal
);

   dec_t dec;
   dec_t out_q;
   logic out_valid_q;
   logic accept;

   rv_alu_dec_comb u_dec (
      .instr (in_instr),
      .dec   (dec)
   );

`ifdef DECODER_SKID_EN
   dec_t skid_q;
   logic skid_valid_q;
   logic rdy_q;
   dec_t out_d;
   dec_t skid_d;
   logic out_valid_d;
   logic skid_valid_d;

   assign in_ready = rdy_q;
   assign accept   = in_valid && rdy_q && !flush;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         // Output slot frees: the older skid word goes first to keep order.
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = accept;
            if (accept) out_d = dec;
         end
      end else if (accept) begin
         // Output stalled: park the word accepted under the registered ready.
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the payload registers are reset as well, because the outputs must read zero while rst is held.
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         rdy_q        <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         rdy_q        <= !skid_valid_d;
      end
   end
`else
   // rst gates in_ready so nothing is offered upstream while the stage is held.
   assign in_ready = !rst && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (!out_valid_q || out_ready) begin
         out_valid_q <= accept;
         if (accept) out_q <= dec;
      end
   end
`endif

   assign out_valid   = out_valid_q;
   assign out_alu_op  = out_q.alu_op;
   assign out_alu_en  = out_q.alu_en;
   assign out_rs1     = out_q.rs1;
   assign out_rs2     = out_q.rs2;
   assign out_rd      = out_q.rd;
   assign out_imm     = out_q.imm;
   assign out_use_imm = out_q.use_imm;
   assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rv_alu_decoder.sv
// -----------------------------------------------------------------------------
// tb_rv_alu_decoder
// Self-checking bench for rv_alu_decoder; works with either DECODER_SKID_EN
// build since it only follows the handshake, never internal state.
// -----------------------------------------------------------------------------
module tb_rv_alu_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_alu_op;
   logic [18:0] out_alu_en;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic [31:0] out_imm;
   logic        out_use_imm;
   logic        out_illegal;

   always #5 clk = ~clk;

   rv_alu_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_alu_op  (out_alu_op),
      .out_alu_en  (out_alu_en),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_rd      (out_rd),
      .out_imm     (out_imm),
      .out_use_imm (out_use_imm),
      .out_illegal (out_illegal)
   );

   typedef struct packed {
      logic [4:0]  op;
      logic [18:0] en;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        use_imm;
      logic        illegal;
   } out_t;

   // One row per legal encoding; the row index is the ALU operation code.
   typedef struct {
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      bit         f7_any;
      bit         shamt;
   } enc_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      out_t        exp;
   } vec_t;

   enc_t  enc_tab[19];
   vec_t  vecs[14];
   out_t  exp_q[$];
   out_t  held;
   bit    stall;
   int    n_tests = 0;
   int    n_fail  = 0;
   int    n_pops  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic out_t dut_out();
      return {out_alu_op, out_alu_en, out_rs1, out_rs2, out_rd, out_imm, out_use_imm, out_illegal};
   endfunction

   function automatic enc_t enc(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [6:0] f7, input bit f7_any, input bit shamt);
      enc_t e;
      e.opc = opc; e.f3 = f3; e.f7 = f7; e.f7_any = f7_any; e.shamt = shamt;
      return e;
   endfunction

   function automatic vec_t mk(input string name, input logic [31:0] instr, input int op,
                               input logic [18:0] en, input int rs1, input int rs2, input int rd,
                               input logic [31:0] imm, input logic use_imm, input logic ill);
      vec_t v;
      v.name = name;
      v.instr = instr;
      v.exp = {5'(op), en, 5'(rs1), 5'(rs2), 5'(rd), imm, use_imm, ill};
      return v;
   endfunction

   // Reference: look the word up in the legal-encoding table.
   function automatic out_t model(input logic [31:0] w);
      out_t r;
      r = '0;
      r.rs1 = w[19:15];
      r.rs2 = w[24:20];
      r.rd  = w[11:7];
      r.illegal = 1'b1;
      for (int i = 0; i < 19; i++) begin
         if (w[6:0] == enc_tab[i].opc && w[14:12] == enc_tab[i].f3 &&
             (enc_tab[i].f7_any || w[31:25] == enc_tab[i].f7)) begin
            r.illegal = 1'b0;
            r.op      = 5'(i);
            r.en      = 19'(1) << i;
            r.use_imm = (w[6:0] == 7'h13);
            if (r.use_imm)
               r.imm = enc_tab[i].shamt ? {27'b0, w[24:20]} : {{20{w[31]}}, w[31:20]};
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] gen_word();
      logic [31:0] r;
      logic [6:0]  opc;
      logic [6:0]  f7;
      r = $urandom();
      case ($urandom_range(0, 3))
         0:       opc = 7'h33;
         1, 2:    opc = 7'h13;
         default: opc = r[6:0];
      endcase
      case ($urandom_range(0, 2))
         0:       f7 = 7'h00;
         1:       f7 = 7'h20;
         default: f7 = 7'($urandom());
      endcase
      return {f7, r[24:7], opc};
   endfunction

   // One clock cycle: drive, sample mid-cycle, score, then advance past the edge.
   task automatic cycle(input logic iv, input logic [31:0] w, input logic ordy,
                        input logic fl, output bit acc);
      in_valid  = iv;
      in_instr  = w;
      out_ready = ordy;
      flush     = fl;
      #2;
      if (stall) begin
         check("hold_valid", 128'(out_valid), 128'(1));
         check("hold_fields", 128'(dut_out()), 128'(held));
      end
      acc = iv && in_ready && !fl;
      if (fl) begin
         exp_q.delete();
         stall = 1'b0;
      end else begin
         if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_out: got %0h expected no output", dut_out());
            end else begin
               check("scoreboard", 128'(dut_out()), 128'(exp_q.pop_front()));
               n_pops++;
            end
         end
         stall = out_valid && !ordy;
         held  = dut_out();
         if (acc) exp_q.push_back(model(w));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit          acc;
      int          idx;
      int          cyc;
      int          pops0;
      logic [31:0] seq_w[3];

      enc_tab[0]  = enc(7'h33, 3'd0, 7'h00, 1'b0, 1'b0);  // ADD
      enc_tab[1]  = enc(7'h13, 3'd0, 7'h00, 1'b1, 1'b0);  // ADDI
      enc_tab[2]  = enc(7'h33, 3'd0, 7'h20, 1'b0, 1'b0);  // SUB
      enc_tab[3]  = enc(7'h33, 3'd4, 7'h00, 1'b0, 1'b0);  // XOR
      enc_tab[4]  = enc(7'h13, 3'd4, 7'h00, 1'b1, 1'b0);  // XORI
      enc_tab[5]  = enc(7'h33, 3'd6, 7'h00, 1'b0, 1'b0);  // OR
      enc_tab[6]  = enc(7'h13, 3'd6, 7'h00, 1'b1, 1'b0);  // ORI
      enc_tab[7]  = enc(7'h33, 3'd7, 7'h00, 1'b0, 1'b0);  // AND
      enc_tab[8]  = enc(7'h13, 3'd7, 7'h00, 1'b1, 1'b0);  // ANDI
      enc_tab[9]  = enc(7'h33, 3'd1, 7'h00, 1'b0, 1'b0);  // SLL
      enc_tab[10] = enc(7'h13, 3'd1, 7'h00, 1'b0, 1'b1);  // SLLI
      enc_tab[11] = enc(7'h33, 3'd5, 7'h00, 1'b0, 1'b0);  // SRL
      enc_tab[12] = enc(7'h13, 3'd5, 7'h00, 1'b0, 1'b1);  // SRLI
      enc_tab[13] = enc(7'h33, 3'd5, 7'h20, 1'b0, 1'b0);  // SRA
      enc_tab[14] = enc(7'h13, 3'd5, 7'h20, 1'b0, 1'b1);  // SRAI
      enc_tab[15] = enc(7'h33, 3'd2, 7'h00, 1'b0, 1'b0);  // SLT
      enc_tab[16] = enc(7'h13, 3'd2, 7'h00, 1'b1, 1'b0);  // SLTI
      enc_tab[17] = enc(7'h33, 3'd3, 7'h00, 1'b0, 1'b0);  // SLTU
      enc_tab[18] = enc(7'h13, 3'd3, 7'h00, 1'b1, 1'b0);  // SLTIU

      //              name          instr         op  en        rs1 rs2 rd  imm           use ill
      vecs[0]  = mk("add",        32'h00A28033, 0,  19'h00001, 5,  10, 0,  32'h0,        0,  0);
      vecs[1]  = mk("addi_m1",    32'hFFF30293, 1,  19'h00002, 6,  31, 5,  32'hFFFFFFFF, 1,  0);
      vecs[2]  = mk("srai",       32'h4053D293, 14, 19'h04000, 7,  5,  5,  32'h5,        1,  0);
      vecs[3]  = mk("srai_bad",   32'h4253D293, 0,  19'h00000, 7,  5,  5,  32'h0,        0,  1);
      vecs[4]  = mk("sub",        32'h403100B3, 2,  19'h00004, 2,  3,  1,  32'h0,        0,  0);
      vecs[5]  = mk("sltu",       32'h0062B233, 17, 19'h20000, 5,  6,  4,  32'h0,        0,  0);
      vecs[6]  = mk("sra",        32'h409453B3, 13, 19'h02000, 8,  9,  7,  32'h0,        0,  0);
      vecs[7]  = mk("mul_ill",    32'h023100B3, 0,  19'h00000, 2,  3,  1,  32'h0,        0,  1);
      vecs[8]  = mk("slli_bad",   32'h41F11093, 0,  19'h00000, 2,  31, 1,  32'h0,        0,  1);
      vecs[9]  = mk("slli",       32'h01F11093, 10, 19'h00400, 2,  31, 1,  32'h1F,       1,  0);
      vecs[10] = mk("sltiu_min",  32'h80023193, 18, 19'h40000, 4,  0,  3,  32'hFFFFF800, 1,  0);
      vecs[11] = mk("andi_max",   32'h7FF5F513, 8,  19'h00100, 11, 31, 10, 32'h7FF,      1,  0);
      vecs[12] = mk("lw_ill",     32'h00002003, 0,  19'h00000, 0,  0,  0,  32'h0,        0,  1);
      vecs[13] = mk("xor_x31",    32'h01FFCFB3, 3,  19'h00008, 31, 31, 31, 32'h0,        0,  0);

      // Reset state, sampled between edges with rst held.
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
      stall = 1'b0;
      #2;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_fields", 128'(dut_out()), 128'(0));
      #10 rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_rst", 128'(in_ready), 128'(1));

      // Directed table: one word at a time, output checked one cycle later.
      foreach (vecs[i]) begin
         in_valid = 1'b1; in_instr = vecs[i].instr; out_ready = 1'b1; flush = 1'b0;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check({vecs[i].name, "_valid"}, 128'(out_valid), 128'(1));
         check(vecs[i].name, 128'(dut_out()), 128'(vecs[i].exp));
      end
      @(posedge clk);
      #1;
      check("table_drained", 128'(out_valid), 128'(0));

      // Back-to-back ADD, SUB, SLTU with a three-cycle downstream stall.
      seq_w[0] = 32'h00A28033; seq_w[1] = 32'h403100B3; seq_w[2] = 32'h0062B233;
      idx = 0; cyc = 0; pops0 = n_pops;
      while ((idx < 3 || exp_q.size() > 0) && cyc < 30) begin
         cycle(idx < 3, (idx < 3) ? seq_w[idx] : 32'h0, !(cyc >= 1 && cyc <= 3), 1'b0, acc);
         if (acc) idx++;
         cyc++;
      end
      check("seq_accepted", 128'(idx), 128'(3));
      check("seq_delivered", 128'(n_pops - pops0), 128'(3));
      check("seq_idle", 128'(out_valid), 128'(0));

      // Flush with a word held at the output and a new word offered.
      cycle(1'b1, 32'h00A28033, 1'b0, 1'b0, acc);
      check("flush_setup", 128'(out_valid), 128'(1));
      cycle(1'b1, 32'h403100B3, 1'b1, 1'b1, acc);
      check("flush_clears", 128'(out_valid), 128'(0));
      cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
      check("flush_discards", 128'(out_valid), 128'(0));

      // Asynchronous reset between edges while a word is held.
      cycle(1'b1, 32'h01FFCFB3, 1'b0, 1'b0, acc);
      check("arst_setup", 128'(out_valid), 128'(1));
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 128'(out_valid), 128'(0));
      check("arst_fields", 128'(dut_out()), 128'(0));
      check("arst_in_ready", 128'(in_ready), 128'(0));
      exp_q.delete();
      stall = 1'b0;
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      check("arst_ready_back", 128'(in_ready), 128'(1));
      check("arst_dropped", 128'(out_valid), 128'(0));

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 3) != 0, gen_word(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 39) == 0, acc);
      end
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 20) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
         cyc++;
      end
      check("random_drained", 128'(exp_q.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_alu_decoder.md
RV_ALU_DECODER -- requirements
Module: rv_alu_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset domain is permitted.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  synchronous pipeline kill.
REQ-005 in_valid  input  1  instruction word present.
REQ-006 in_ready  output  1  decoder accepts the word this cycle.
REQ-007 in_instr  input  32  RV32I instruction word.
REQ-008 out_valid  output  1  decoded bundle present.
REQ-009 out_ready  input  1  ALU stage accepts the bundle.
REQ-010 out_alu_op  output  5  ALU operation code, per REQ-014.
REQ-011 out_alu_en  output  19  one-hot enable; bit i is asserted when out_alu_op == i.
REQ-012 out_rs1, out_rs2, out_rd  output  5 each  register addresses: instr[19:15], [24:20], [11:7].
REQ-013 out_imm  output  32  immediate; out_use_imm output 1 selects the immediate as ALU input2; out_illegal output 1 flags an unsupported word.

Function
REQ-014 Operation codes SHALL be: ADD 0, ADDI 1, SUB 2, XOR 3, XORI 4, OR 5, ORI 6, AND 7, ANDI 8, SLL 9, SLLI 10, SRL 11, SRLI 12, SRA 13, SRAI 14, SLT 15, SLTI 16, SLTU 17, SLTIU 18.
REQ-015 opcode 0110011 SHALL decode as R-type from funct3 and funct7: funct7 0100000 is legal only with funct3 000 (SUB) or 101 (SRA); every other R-type word requires funct7 0000000.
REQ-016 opcode 0010011 SHALL decode as I-type from funct3. SLLI requires instr[31:25]==0000000. SRLI requires instr[31:25]==0000000. SRAI requires instr[31:25]==0100000.
REQ-017 out_imm SHALL be the sign-extension of instr[31:20] for non-shift I-type words and the zero-extension of instr[24:20] for SLLI, SRLI and SRAI; it SHALL be 0 for R-type words.
REQ-018 out_use_imm SHALL be 1 for I-type words and 0 otherwise.
REQ-019 Any other opcode or field combination SHALL give out_illegal=1, out_alu_op=0, out_alu_en=0 and out_use_imm=0; the word still flows through the handshake.
REQ-020 A transfer SHALL occur on a rising edge where valid and ready are both 1. Latency SHALL be one cycle from input acceptance to out_valid; sustained throughput SHALL be one word per cycle.
REQ-021 While out_valid=1 and out_ready=0, every out_* field SHALL hold stable.
REQ-022 flush=1 SHALL clear all valid state on the next edge and SHALL discard any simultaneous input; the input is not accepted even if in_valid=1.
REQ-023 Decode of in_instr SHALL be combinational before the output register; no other state exists.

Reset
REQ-024 On rst assertion, out_valid SHALL be 0 and all stored entries SHALL be invalid, asynchronously.
REQ-025 While rst is asserted, out_alu_op, out_alu_en, out_rs1, out_rs2, out_rd, out_imm, out_use_imm and out_illegal SHALL be 0.
REQ-026 While rst is asserted, in_ready SHALL be 0. After rst deasserts, in_ready SHALL be 1 no later than the first rising edge.
REQ-027 A reset mid-transfer SHALL drop the in-flight word without producing an output.

Configuration
REQ-028 Macro DECODER_SKID_EN: when defined, the block SHALL use a two-entry skid buffer and in_ready SHALL be a register output (in_ready = skid entry empty), so there is no combinational path from out_ready to in_ready.
REQ-029 When DECODER_SKID_EN is undefined, the block SHALL use a single output register, with in_ready = !out_valid || out_ready.
REQ-030 Ordering, latency and field values SHALL be identical in both builds.

Structure
REQ-031 The opcode constants, funct3/funct7 constants and the 5-bit ALU operation codes SHALL live in a shared package, rv_alu_pkg, which the ALU also imports.
REQ-032 The combinational decoder SHALL be one sub-module, rv_alu_dec_comb; the handshake and registers SHALL stay in the top module.

Verification
REQ-033 0x00A28033 (add x0,x5,x10) -> one cycle later: alu_op=0, alu_en=0x00001, rs1=5, rs2=10, use_imm=0.
REQ-034 0xFFF30293 (addi x5,x6,-1) -> alu_op=1, imm=0xFFFFFFFF, use_imm=1.
REQ-035 0x4053D293 (srai x5,x7,5) -> alu_op=14, imm=5; the same word with bit 25 set -> illegal=1, alu_en=0.
REQ-036 Back-to-back ADD, SUB, SLTU with out_ready held 0 for 3 cycles -> outputs stable, nothing lost, order preserved; run in both DECODER_SKID_EN builds.
REQ-037 flush asserted together with in_valid=1 and out_valid=1 -> out_valid=0 next cycle and the new word is discarded.
REQ-038 rst asserted between edges while out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge.
